// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate cache
// with one-word lines and saturating load hit/miss counters.
// Ports: clk; rst (async, active-low).
//   cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out.
//   flush in (invalidate all lines, serviced in IDLE only).
//   mem_req/mem_we/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
//   hit_cnt/miss_cnt out (16-bit load counters).
// SETS must be a power of two, at least 2.
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } state_t;

    state_t                state;
    logic [SETS-1:0]       valid;
    logic [TW-1:0]         tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit;
    logic          addr_unused;

    assign idx = cpu_addr[IW+1:2];
    assign tag = cpu_addr[31:IW+2];
    assign hit = valid[idx] && (tags[idx] == tag);

    // byte offset does not select anything in a word cache
    assign addr_unused = ^cpu_addr[1:0];

    // Same read port serves IDLE hits and the RESP cycle after a fill,
    // since the fill writes the line at the FILL->RESP edge.
    assign cpu_rdata = data[idx];

    // Stall must be combinational in IDLE for 0-wait-state hits.
    always_comb begin
        cpu_stall = 1'b0;
        unique case (state)
            IDLE:  cpu_stall = flush ||
                               (cpu_req && (cpu_we || !hit));
            FILL:  cpu_stall = 1'b1;
            WRITE: cpu_stall = 1'b1;
            RESP:  cpu_stall = 1'b0;
            default: cpu_stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            valid     <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (cpu_req) begin
                        // latched once; cpu_* are held while stalled
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        mem_wdata <= cpu_wdata;
                        if (cpu_we) begin
                            state   <= WRITE;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b1;
                        end else if (!hit) begin
                            state   <= FILL;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            if (miss_cnt != 16'hFFFF)
                                miss_cnt <= miss_cnt + 16'd1;
                        end else if (hit_cnt != 16'hFFFF) begin
                            hit_cnt <= hit_cnt + 16'd1;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        valid[idx] <= 1'b1;
                        mem_req    <= 1'b0;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ready) begin
            data[idx] <= mem_rdata;
            tags[idx] <= tag;
        end else if (state == WRITE && mem_ready && hit) begin
            data[idx] <= cpu_wdata;
        end
    end

endmodule
